filt4_level_tx: RTL and testbench

//  Transmit side of the filt4 glitch-filter link. Accepts single bits over a valid/ready

---
 rtl/filt4_level_tx.sv | 93 +++++++++
 tb/tb_filt4_level_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/filt4_level_tx.sv
// Transmit side of the filt4 glitch-filter link. Each accepted bit is driven on y as a
// level held for HOLD enable ticks. A one-entry buffer lets back-to-back bits run gap-free.
module filt4_level_tx #(
    parameter int   HOLD     = 12,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic y,
    output logic busy
);

    localparam int CW = $clog2(HOLD + 1);

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("filt4_level_tx: HOLD must be in 1..255");
    end

    typedef enum logic {StIdle, StHold} state_t;

    state_t          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic            r_y, w_y_d;
    logic            r_pend_bit, w_pend_bit_d;
    logic            r_pend_vld, w_pend_vld_d;
    logic            w_accept;
    logic            w_final;

    assign in_ready = !r_pend_vld;
    assign w_accept = in_valid && in_ready;
    assign w_final  = (r_state == StHold) && en && (r_cnt == CW'(HOLD - 1));
    assign y        = r_y;
    assign busy     = (r_state == StHold) || r_pend_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_y        <= IDLE_LVL;
            r_pend_bit <= 1'b0;
            r_pend_vld <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_y        <= w_y_d;
            r_pend_bit <= w_pend_bit_d;
            r_pend_vld <= w_pend_vld_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_y_d        = r_y;
        w_pend_bit_d = r_pend_bit;
        w_pend_vld_d = r_pend_vld;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_y_d     = in_bit;
                    w_cnt_d   = '0;
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (en) begin
                    w_cnt_d = r_cnt + CW'(1);
                end
                if (w_final) begin
                    // Pending bit wins; otherwise a same-cycle offer bypasses the buffer.
                    w_cnt_d = '0;
                    if (r_pend_vld) begin
                        w_y_d        = r_pend_bit;
                        w_pend_vld_d = 1'b0;
                    end else if (w_accept) begin
                        w_y_d = in_bit;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_accept) begin
                    w_pend_bit_d = in_bit;
                    w_pend_vld_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_filt4_level_tx.sv
// Self-checking bench for filt4_level_tx: a constant vector table, hand sequences for the
// corner cases, and random traffic checked against a queue-based model of the line.
module tb_filt4_level_tx;

    localparam int   HOLD = 12;
    localparam logic IDLE = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_ready, y, busy;

    filt4_level_tx #(.HOLD(HOLD), .IDLE_LVL(IDLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .in_ready (in_ready),
        .y        (y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // Model: queue of accepted bits; head is on the line, at most one waits behind it.
    bit   mq[$];
    int   m_served;
    logic m_y;
    bit   sent[$];
    bit   ystream[$];

    typedef struct {
        logic v, b, e;
        logic ey, eb, er;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_served = 0;
        m_y = IDLE;
        sent.delete();
        ystream.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_y", y, IDLE);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", in_ready, 1'b1);
    endtask

    task automatic step(input logic v, input logic b, input logic e, input bit do_chk);
        bit acc, was;
        @(negedge clk);
        in_valid = v; in_bit = b; en = e;
        #1;
        acc = v && (mq.size() < 2);
        was = mq.size() > 0;
        if (do_chk) chk("ready_pre", in_ready, mq.size() < 2);
        if (was && e) ystream.push_back(y);
        @(posedge clk);
        if (acc) begin
            mq.push_back(b);
            sent.push_back(b);
        end
        if (was && e) begin
            m_served++;
            if (m_served == HOLD) begin
                void'(mq.pop_front());
                m_served = 0;
            end
        end
        if (mq.size() > 0) m_y = mq[0];
        #1;
        if (do_chk) begin
            chk("y", y, m_y);
            chk("busy", busy, mq.size() > 0);
            chk("ready", in_ready, mq.size() < 2);
        end
    endtask

    // Every transmitted bit must appear on y for exactly HOLD counted ticks, in order.
    task automatic check_stream(input string nm);
        bit ok;
        n_chk++;
        if (ystream.size() != HOLD * sent.size()) begin
            n_err++;
            $display("FAIL %s_len: got %0d ticks expected %0d", nm, ystream.size(),
                     HOLD * sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                ok = 1'b1;
                for (int k = 0; k < HOLD; k++) begin
                    if (ystream[i * HOLD + k] != sent[i]) ok = 1'b0;
                end
                n_chk++;
                if (!ok) begin
                    n_err++;
                    $display("FAIL %s_bit%0d: got corrupted level expected %b", nm, i, sent[i]);
                end
            end
        end
    endtask

    initial begin
        int busy_cycles;

        // Back-to-back 1,0,1 with en=1; buffer use, gap-free hand-over, then idle at 1.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        repeat (10) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        repeat (10) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        repeat (11) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].e, 1'b0);
            chk($sformatf("tbl%0d_y", i), y, tbl[i].ey);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
        end
        check_stream("tbl_stream");

        // en every third cycle: busy spans 36 clocks for one bit.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1);
        busy_cycles = 1;
        for (int k = 1; k < 60; k++) begin
            step(1'b0, 1'b0, (k % 3) == 0, 1'b1);
            if (busy) busy_cycles++;
        end
        n_chk++;
        if (busy_cycles != 3 * HOLD) begin
            n_err++;
            $display("FAIL slow_en_busy: got %0d cycles expected %0d", busy_cycles, 3 * HOLD);
        end
        check_stream("slow_stream");

        // Bypass: offer exactly on the final tick with the buffer empty.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (HOLD - 1) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("bypass_busy", busy, 1'b1);
        chk("bypass_y", y, 1'b0);
        repeat (HOLD + 2) step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("bypass_done_busy", busy, 1'b0);
        check_stream("bypass_stream");

        // Reset at tick 5 of a hold with a pending bit: drops everything at once.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_ready", in_ready, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_y", y, IDLE);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();

        // Random traffic under three en regimes, drained and checked bit-by-bit.
        for (int mode = 0; mode < 3; mode++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                logic e;
                case (mode)
                    0:       e = 1'b1;
                    1:       e = (c % 3) == 0;
                    default: e = $urandom_range(0, 1) == 1;
                endcase
                step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, e, 1'b1);
            end
            repeat (3 * HOLD) step(1'b0, 1'b0, 1'b1, 1'b1);
            chk("drain_busy", busy, 1'b0);
            check_stream($sformatf("rand%0d", mode));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
